// File: rtl/ila_pkg.sv
// Shared definitions for the ILA capture path: state encoding and default sizes.
// The register map reuses the state constants for its status word.
package ila_pkg;

  localparam int ILA_DATA_WIDTH = 64;
  localparam int ILA_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ILA_ST_IDLE      = 2'd0,
    ILA_ST_ARMED     = 2'd1,
    ILA_ST_TRIGGERED = 2'd2,
    ILA_ST_DONE      = 2'd3
  } ila_state_e;

endpackage : ila_pkg

// File: rtl/ila_trig_match.sv
// Masked equality comparator: hit when every bit selected by mask equals value.
// Kept separate so later multi-stage triggers can stack several instances.
module ila_trig_match #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mask,
  output logic             hit
);

  assign hit = (((data ^ value) & mask) == '0);

endmodule : ila_trig_match

// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: drives BRAM port A through arm/pre-fill/trigger/post
// capture, then serves oldest-first readout through BRAM port B.
module ila_capture_ctrl
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = ILA_DATA_WIDTH,
  parameter int ADDR_WIDTH = ILA_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [ADDR_WIDTH-1:0] post_depth,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  output logic                  bram_enb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            state_o,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH:0]   sample_count
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  ila_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
  logic                  enb_q, enb_d;
  logic                  dvalid_q, dvalid_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  hit;
  logic                  start;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] base;

  ila_trig_match #(.WIDTH(DATA_WIDTH)) u_trig_match (
    .data  (data_in),
    .value (trig_value),
    .mask  (trig_mask),
    .hit   (hit)
  );

  // A fresh capture starts from IDLE or DONE; abort always takes priority.
  assign start = arm && !abort && (state_q == ILA_ST_IDLE || state_q == ILA_ST_DONE);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= ILA_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (abort) begin
      state_d = ILA_ST_IDLE;
    end else begin
      case (state_q)
        ILA_ST_IDLE, ILA_ST_DONE: if (arm) state_d = ILA_ST_ARMED;
        ILA_ST_ARMED:
          if (hit) state_d = (post_depth == '0) ? ILA_ST_DONE : ILA_ST_TRIGGERED;
        ILA_ST_TRIGGERED:
          if (post_cnt_q == ADDR_WIDTH'(1)) state_d = ILA_ST_DONE;
        default: state_d = ILA_ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- datapath / outputs
  always_comb begin
    // The write enable is registered, so it follows whichever state we enter.
    wea_d       = (state_d == ILA_ST_ARMED) || (state_d == ILA_ST_TRIGGERED);
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;

    if (start) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (wea_q) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + (ADDR_WIDTH + 1)'(1);
    end

    if (!abort && state_q == ILA_ST_ARMED && hit) begin
      trig_addr_d = wr_ptr_q;
      post_cnt_d  = post_depth;
    end else if (state_q == ILA_ST_TRIGGERED && wea_q) begin
      post_cnt_d  = post_cnt_q - ADDR_WIDTH'(1);
    end

    // Once the buffer has wrapped, the next write slot holds the oldest sample.
    base      = (fill_q == FILL_MAX) ? wr_ptr_q : '0;
    rd_accept = rd_req && (state_q == ILA_ST_DONE) && !enb_q && !dvalid_q;
    addrb_d   = rd_accept ? (base + rd_index) : addrb_q;
    enb_d     = rd_accept;
    dvalid_d  = enb_q;
    rd_valid_d = dvalid_q;
    rd_data_d  = dvalid_q ? bram_doutb : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      wea_q       <= 1'b0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      addrb_q     <= '0;
      enb_q       <= 1'b0;
      dvalid_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      wea_q       <= wea_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      addrb_q     <= addrb_d;
      enb_q       <= enb_d;
      dvalid_q    <= dvalid_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bram_addra   = wr_ptr_q;
  assign bram_wea     = wea_q;
  assign bram_addrb   = addrb_q;
  assign bram_enb     = enb_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign state_o      = state_q;
  assign trig_addr    = trig_addr_q;
  assign sample_count = fill_q;

endmodule : ila_capture_ctrl

// File: tb/tb_ila_capture_ctrl.sv
// Testbench for ila_capture_ctrl: BRAM model plus a sample-stream reference
// that predicts trigger position, sample count and oldest-first readout.
module tb_ila_capture_ctrl;
  import ila_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int SLEN  = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, rd_req;
  logic [DW-1:0] trig_value, trig_mask, data_in, bram_doutb, rd_data;
  logic [AW-1:0] post_depth, bram_addra, bram_addrb, rd_index, trig_addr;
  logic          bram_wea, bram_enb, rd_valid;
  logic [1:0]    state_o;
  logic [AW:0]   sample_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] stream [SLEN];
  int            m_total;
  int            m_trig;

  always #5 clk = ~clk;

  ila_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .trig_value   (trig_value),
    .trig_mask    (trig_mask),
    .post_depth   (post_depth),
    .data_in      (data_in),
    .bram_addra   (bram_addra),
    .bram_wea     (bram_wea),
    .bram_addrb   (bram_addrb),
    .bram_enb     (bram_enb),
    .bram_doutb   (bram_doutb),
    .rd_req       (rd_req),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .state_o      (state_o),
    .trig_addr    (trig_addr),
    .sample_count (sample_count)
  );

  // Dual-port BRAM: port A write, port B registered read.
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= data_in;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sample k of a capture is stream[k]; the trigger is the first
  // masked match; exactly pd samples follow it.
  function automatic logic [63:0] exp_sample(input int idx);
    if (m_total <= DEPTH) return stream[idx];
    return stream[m_total - DEPTH + idx];
  endfunction

  function automatic int exp_count();
    return (m_total > DEPTH) ? DEPTH : m_total;
  endfunction

  function automatic int exp_base();
    return (m_total >= DEPTH) ? (m_total % DEPTH) : 0;
  endfunction

  task automatic run_capture(input logic [63:0] val, input logic [63:0] mask, input int pd);
    int t;
    t = -1;
    for (int i = 0; i < SLEN - 300; i++)
      if (t < 0 && ((stream[i] ^ val) & mask) == 64'd0) t = i;
    if (t < 0) begin
      $display("FAIL model: stimulus stream holds no trigger");
      $fatal(1);
    end
    m_trig     = t;
    m_total    = t + 1 + pd;
    trig_value = val;
    trig_mask  = mask;
    post_depth = AW'(pd);
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    check("first_cycle_armed", state_o, ILA_ST_ARMED);
    for (int k = 0; k < m_total; k++) begin
      data_in = stream[k];
      check("wea_window", bram_wea, 1'b1);
      check("addra_seq", bram_addra, k % DEPTH);
      @(negedge clk);
    end
    data_in = '0;
    check("done_state", state_o, ILA_ST_DONE);
    check("wea_off_after", bram_wea, 1'b0);
    check("sample_count", sample_count, exp_count());
    check("trig_addr", trig_addr, m_trig % DEPTH);
  endtask

  task automatic do_read(input int idx);
    @(negedge clk);
    rd_req   = 1'b1;
    rd_index = AW'(idx);
    @(negedge clk);
    rd_req = 1'b0;
    check("rd_enb", bram_enb, 1'b1);
    check("rd_addrb", bram_addrb, (exp_base() + idx) % DEPTH);
    @(negedge clk);
    check("rd_enb_single", bram_enb, 1'b0);
    check("rd_valid_early", rd_valid, 1'b0);
    @(negedge clk);
    check("rd_valid", rd_valid, 1'b1);
    check("rd_data", rd_data, exp_sample(idx));
  endtask

  task automatic check_all_zero();
    check("rst_state", state_o, ILA_ST_IDLE);
    check("rst_wea", bram_wea, 1'b0);
    check("rst_addra", bram_addra, 0);
    check("rst_enb", bram_enb, 1'b0);
    check("rst_addrb", bram_addrb, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_sample_count", sample_count, 0);
  endtask

  initial begin
    int n_enb, n_val, p, pd;
    logic [63:0] val, mask;

    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; rd_req = 1'b0; rd_index = '0;
    trig_value = '0; trig_mask = '0; post_depth = '0; data_in = '0;
    #1 check_all_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: mask 0 triggers on first armed cycle, 3 post samples.
    for (int i = 0; i < SLEN; i++) stream[i] = {$urandom, $urandom};
    run_capture(64'd0, 64'd0, 3);
    for (int i = 0; i < 4; i++) do_read(i);

    // post_depth 0: trigger sample is the only write.
    for (int i = 0; i < SLEN; i++) stream[i] = {$urandom, $urandom};
    run_capture(64'd0, 64'd0, 0);
    do_read(0);

    // 2: byte match on a counter, no wrap.
    for (int i = 0; i < SLEN; i++) stream[i] = 64'(i);
    run_capture(64'h5A, 64'hFF, 10);
    do_read(0);
    do_read(100);

    // 3: wrap, buffer saturated, oldest-first base.
    run_capture(64'd300, '1, 20);
    do_read(0);
    do_read(255);
    do_read(128);

    // Randomised captures with a sparse mask and a planted match.
    for (int r = 0; r < 4; r++) begin
      mask = '0;
      for (int j = 0; j < 4; j++) mask[$urandom_range(63, 0)] = 1'b1;
      val = {$urandom, $urandom};
      for (int i = 0; i < SLEN; i++) stream[i] = {$urandom, $urandom};
      p  = $urandom_range(500, 0);
      pd = $urandom_range(40, 0);
      stream[p] = (stream[p] & ~mask) | (val & mask);
      run_capture(val, mask, pd);
      for (int j = 0; j < 3; j++) do_read($urandom_range(exp_count() - 1, 0));
    end

    // 5: back-to-back rd_req, only the first is serviced.
    @(negedge clk);
    rd_req = 1'b1; rd_index = 8'd0;
    @(negedge clk);
    rd_req = 1'b1; rd_index = 8'd1;
    n_enb = 0; n_val = 0;
    for (int i = 0; i < 6; i++) begin
      if (bram_enb) n_enb++;
      if (rd_valid) n_val++;
      rd_req = 1'b0;
      @(negedge clk);
    end
    check("b2b_enb_count", n_enb, 1);
    check("b2b_valid_count", n_val, 1);
    check("b2b_rd_data", rd_data, exp_sample(0));

    // 5b: rd_req while ARMED is ignored.
    trig_value = '1; trig_mask = '1; post_depth = 8'd5; data_in = '0;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    n_enb = 0; n_val = 0;
    for (int i = 0; i < 4; i++) begin
      if (bram_enb) n_enb++;
      if (rd_valid) n_val++;
      @(negedge clk);
    end
    check("armed_rd_enb", n_enb, 0);
    check("armed_rd_valid", n_val, 0);
    check("still_armed", state_o, ILA_ST_ARMED);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_armed", state_o, ILA_ST_IDLE);

    // 4: abort with simultaneous arm during TRIGGERED, then again in IDLE.
    trig_mask = '0; post_depth = 8'd50;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    repeat (4) @(negedge clk);
    check("in_triggered", state_o, ILA_ST_TRIGGERED);
    abort = 1'b1; arm = 1'b1;
    @(negedge clk);
    check("abort_trig_state", state_o, ILA_ST_IDLE);
    check("abort_trig_wea", bram_wea, 1'b0);
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    check("abort_arm_idle", state_o, ILA_ST_IDLE);
    check("abort_arm_wea", bram_wea, 1'b0);

    // 6: asynchronous reset mid-TRIGGERED, then a clean capture.
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_triggered", state_o, ILA_ST_TRIGGERED);
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < SLEN; i++) stream[i] = {$urandom, $urandom};
    run_capture(64'd0, 64'd0, 3);
    do_read(0);
    do_read(3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ila_capture_ctrl
